// File: rtl/fault_batch_sequencer.sv
// Batch sequencer for a bit-parallel stuck-at fault simulator: drives exhaustive patterns, accumulates lane mismatches.
// Optional feature macro EARLY_DROP_EN: stop a batch as soon as every valid lane has been detected.
module fault_batch_sequencer #(
  parameter int unsigned LANES      = 8,
  parameter int unsigned NUM_FAULTS = 20,
  parameter int unsigned NUM_INPUTS = 5,
  parameter int unsigned DP_LAT     = 1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  output logic                            busy,
  output logic                            done,
  output logic [NUM_INPUTS-1:0]           pat,
  output logic                            pat_valid,
  output logic [7:0]                      batch,
  input  logic [LANES-1:0]                resp,
  output logic                            det_we,
  output logic [7:0]                      det_addr,
  output logic [LANES-2:0]                det_mask,
  output logic [$clog2(NUM_FAULTS+1)-1:0] det_count
);

  localparam int unsigned FL = LANES - 1;
  localparam int unsigned NB = (NUM_FAULTS + FL - 1) / FL;
  localparam int unsigned CW = $clog2(NUM_FAULTS + 1);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_DRAIN, S_WRITE, S_DONE} state_t;

  state_t                r_state;
  state_t                w_state_nx;
  logic [NUM_INPUTS-1:0] r_pat;
  logic                  r_pat_valid;
  logic [7:0]            r_batch;
  logic [FL-1:0]         r_acc;
  logic [1:0]            r_drain;
  logic [2:0]            r_vpipe;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_det_we;
  logic [7:0]            r_det_addr;
  logic [FL-1:0]         r_det_mask;
  logic [CW-1:0]         r_det_count;

  logic                  w_dvalid;
  logic [FL-1:0]         w_valid_mask;
  logic [FL-1:0]         w_acc_nx;
  logic                  w_last_batch;
  logic                  w_stop;
  logic [CW-1:0]         w_pop;

  // Response-valid strobe aligned to the datapath latency
  always_comb begin
    w_dvalid = r_vpipe[2];
    if (DP_LAT == 0)      w_dvalid = r_pat_valid;
    else if (DP_LAT == 1) w_dvalid = r_vpipe[0];
    else if (DP_LAT == 2) w_dvalid = r_vpipe[1];
  end

  // Lanes beyond the end of the fault list never count as detections
  always_comb begin
    w_valid_mask = '0;
    for (int unsigned k = 0; k < FL; k++)
      w_valid_mask[k] = ((32'(r_batch) * FL + k) < NUM_FAULTS);
  end

  always_comb begin
    w_acc_nx = r_acc;
    if (w_dvalid)
      w_acc_nx = r_acc | ((resp[LANES-1:1] ^ {FL{resp[0]}}) & w_valid_mask);
  end

  always_comb begin
    w_pop = '0;
    for (int unsigned k = 0; k < FL; k++)
      w_pop = w_pop + CW'(r_det_mask[k]);
  end

  assign w_last_batch = (r_batch == 8'(NB - 1));
`ifdef EARLY_DROP_EN
  assign w_stop = (&r_pat) || (w_acc_nx == w_valid_mask);
`else
  assign w_stop = &r_pat;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nx = S_ISSUE;
      S_ISSUE: if (w_stop) w_state_nx = (DP_LAT == 0) ? S_WRITE : S_DRAIN;
      S_DRAIN: if (r_drain == 2'(DP_LAT - 1)) w_state_nx = S_WRITE;
      S_WRITE: w_state_nx = w_last_batch ? S_DONE : S_ISSUE;
      S_DONE:  w_state_nx = S_IDLE;
      default: w_state_nx = S_IDLE;
    endcase
  end

  // Registered outputs are decoded from the next state so they align with the state they describe
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pat       <= '0;
      r_pat_valid <= 1'b0;
      r_batch     <= '0;
      r_acc       <= '0;
      r_drain     <= '0;
      r_vpipe     <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_det_we    <= 1'b0;
      r_det_addr  <= '0;
      r_det_mask  <= '0;
      r_det_count <= '0;
    end else begin
      r_vpipe     <= {r_vpipe[1:0], r_pat_valid};
      r_pat_valid <= (w_state_nx == S_ISSUE);
      r_busy      <= (w_state_nx == S_ISSUE) || (w_state_nx == S_DRAIN) || (w_state_nx == S_WRITE);
      r_done      <= (w_state_nx == S_DONE);
      r_det_we    <= (w_state_nx == S_WRITE);
      r_acc       <= w_acc_nx;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_det_count <= '0;
            r_batch     <= '0;
            r_pat       <= '0;
            r_acc       <= '0;
          end
        end
        S_ISSUE: begin
          r_drain <= '0;
          if (w_state_nx == S_ISSUE) r_pat <= r_pat + 1'b1;
        end
        S_DRAIN: r_drain <= r_drain + 2'd1;
        S_WRITE: begin
          r_det_count <= r_det_count + w_pop;
          if (!w_last_batch) begin
            r_batch <= r_batch + 8'd1;
            r_pat   <= '0;
            r_acc   <= '0;
          end
        end
        default: ;
      endcase
      if (w_state_nx == S_WRITE) begin
        r_det_mask <= w_acc_nx;
        r_det_addr <= r_batch;
      end
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign pat       = r_pat;
  assign pat_valid = r_pat_valid;
  assign batch     = r_batch;
  assign det_we    = r_det_we;
  assign det_addr  = r_det_addr;
  assign det_mask  = r_det_mask;
  assign det_count = r_det_count;

endmodule

// File: tb/tb_fault_batch_sequencer.sv
// Scoreboard bench for fault_batch_sequencer: DP_LAT=1 instance for most runs, DP_LAT=3 instance for the late-pattern fault.
module tb_fault_batch_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, start, start3;
  logic       busy, done, pat_valid, det_we;
  logic [4:0] pat, det_count;
  logic [7:0] batch, det_addr, resp;
  logic [6:0] det_mask;
  logic       busy3, done3, pat_valid3, det_we3;
  logic [4:0] pat3, det_count3;
  logic [7:0] batch3, det_addr3, resp3;
  logic [6:0] det_mask3;

  fault_batch_sequencer #(.LANES(8), .NUM_FAULTS(20), .NUM_INPUTS(5), .DP_LAT(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done), .pat(pat),
    .pat_valid(pat_valid), .batch(batch), .resp(resp), .det_we(det_we),
    .det_addr(det_addr), .det_mask(det_mask), .det_count(det_count));

  fault_batch_sequencer #(.LANES(8), .NUM_FAULTS(20), .NUM_INPUTS(5), .DP_LAT(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .busy(busy3), .done(done3), .pat(pat3),
    .pat_valid(pat_valid3), .batch(batch3), .resp(resp3), .det_we(det_we3),
    .det_addr(det_addr3), .det_mask(det_mask3), .det_count(det_count3));

  // Datapath stand-in: lane 0 is the good machine, scenario decides which lanes diverge
  function automatic logic [7:0] dp_f(input int sc, input logic [7:0] b, input logic [4:0] p);
    logic [7:0] v;
    v = {8{p[2]}};
    if ((sc == 1 || sc == 2) && p == 5'd0) v[7:1] = ~v[7:1];
    if (sc == 2 && b == 8'd2) v[7] = ~p[2];
    if (sc == 3 && b == 8'd1 && p == 5'd31) v[3] = ~p[2];
    return v;
  endfunction

  int scen = 0;
  logic [7:0] p3a, p3b;
  always @(posedge clk) resp <= dp_f(scen, batch, pat);
  always @(posedge clk) begin
    p3a   <= dp_f(3, batch3, pat3);
    p3b   <= p3a;
    resp3 <= p3b;
  end

  typedef struct packed {logic [7:0] addr; logic [6:0] mask;} rec_t;
  typedef struct packed {logic [4:0] cnt; logic [31:0] dcyc; logic [31:0] pv;} fin_t;
  rec_t q_rec[$], q3_rec[$];
  fin_t q_fin[$], q3_fin[$];

  int n_cmp = 0, n_bad = 0;
  int cyc = 0, start_cyc = 0, start3_cyc = 0;
  int pv_tot = 0, pv_base = 0, pv3_tot = 0, pv3_base = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: pops expectations whenever a DUT presents a record or finishes
  initial forever begin
    rec_t r;
    fin_t f;
    @(posedge clk);
    #1;
    cyc++;
    if (pat_valid)  pv_tot++;
    if (pat_valid3) pv3_tot++;
    if (det_we) begin
      if (q_rec.size() == 0) chk("unexpected_det_we", 1, 0);
      else begin
        r = q_rec.pop_front();
        chk("det_addr", 32'(det_addr), 32'(r.addr));
        chk("det_mask", 32'(det_mask), 32'(r.mask));
      end
    end
    if (done) begin
      if (q_fin.size() == 0) chk("unexpected_done", 1, 0);
      else begin
        f = q_fin.pop_front();
        chk("done_cycle", 32'(cyc - start_cyc), f.dcyc);
        chk("det_count", 32'(det_count), 32'(f.cnt));
        chk("pat_valid_cycles", 32'(pv_tot - pv_base), f.pv);
      end
    end
    if (det_we3) begin
      if (q3_rec.size() == 0) chk("unexpected_det_we3", 1, 0);
      else begin
        r = q3_rec.pop_front();
        chk("det_addr3", 32'(det_addr3), 32'(r.addr));
        chk("det_mask3", 32'(det_mask3), 32'(r.mask));
      end
    end
    if (done3) begin
      if (q3_fin.size() == 0) chk("unexpected_done3", 1, 0);
      else begin
        f = q3_fin.pop_front();
        chk("done_cycle3", 32'(cyc - start3_cyc), f.dcyc);
        chk("det_count3", 32'(det_count3), 32'(f.cnt));
        chk("pat_valid_cycles3", 32'(pv3_tot - pv3_base), f.pv);
      end
    end
  end

  task automatic launch(input int sc, input int nrec, input bit with_fin);
    logic [6:0] m [3];
    int c, d, pv;
    rec_t r;
    fin_t f;
    case (sc)
      1, 2:    begin m[0] = 7'h7F; m[1] = 7'h7F; m[2] = 7'h3F; c = 20; end
      3:       begin m[0] = 7'h00; m[1] = 7'h04; m[2] = 7'h00; c = 1; end
      default: begin m[0] = 7'h00; m[1] = 7'h00; m[2] = 7'h00; c = 0; end
    endcase
    d  = (sc == 3) ? 109 : 103;
    pv = 96;
`ifdef EARLY_DROP_EN
    if (sc == 1 || sc == 2) begin d = 13; pv = 6; end
`endif
    for (int i = 0; i < nrec; i++) begin
      r.addr = 8'(i);
      r.mask = m[i];
      if (sc == 3) q3_rec.push_back(r); else q_rec.push_back(r);
    end
    f.cnt = 5'(c); f.dcyc = 32'(d); f.pv = 32'(pv);
    if (with_fin) begin
      if (sc == 3) q3_fin.push_back(f); else q_fin.push_back(f);
    end
    @(negedge clk);
    if (sc == 3) begin
      start3 = 1'b1; start3_cyc = cyc; pv3_base = pv3_tot;
    end else begin
      scen = sc; start = 1'b1; start_cyc = cyc; pv_base = pv_tot;
    end
    @(negedge clk);
    start = 1'b0;
    start3 = 1'b0;
  endtask

  task automatic wait_done(input bit which3);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if ((which3 ? done3 : done) === 1'b1) begin seen = 1'b1; break; end
    end
    if (!seen) chk("done_timeout", 0, 1);
    @(negedge clk);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"},      32'(busy), 0);
    chk({tag, "_done"},      32'(done), 0);
    chk({tag, "_pat"},       32'(pat), 0);
    chk({tag, "_pat_valid"}, 32'(pat_valid), 0);
    chk({tag, "_batch"},     32'(batch), 0);
    chk({tag, "_det_we"},    32'(det_we), 0);
    chk({tag, "_det_addr"},  32'(det_addr), 0);
    chk({tag, "_det_mask"},  32'(det_mask), 0);
    chk({tag, "_det_count"}, 32'(det_count), 0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; start3 = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_outputs("rst");
    rst_n = 1'b1;

    launch(3, 3, 1'b1); wait_done(1'b1);
    launch(0, 3, 1'b1); wait_done(1'b0);
    launch(1, 3, 1'b1); wait_done(1'b0);
    launch(2, 3, 1'b1); wait_done(1'b0);

    // Mid-run: stray start in batch 1, then a one-cycle reset at cycle 50
    launch(0, 1, 1'b0);
    while (cyc < start_cyc + 40) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (cyc < start_cyc + 50) @(negedge clk);
    chk("mid_busy", 32'(busy), 1);
    chk("mid_batch", 32'(batch), 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk_reset_outputs("midrst");
    rst_n = 1'b1;
    launch(1, 3, 1'b1); wait_done(1'b0);

    repeat (5) @(negedge clk);
    chk("pending_expectations", 32'(q_rec.size() + q_fin.size() + q3_rec.size() + q3_fin.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
